// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU command-side sequencer.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int FLG_ZERO = 0;
  localparam int FLG_NAN  = 1;
  localparam int FLG_INF  = 2;
  localparam int FLG_ERR  = 3;
  localparam int FLG_TMO  = 4;
  localparam int FLAG_W   = 5;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // Places each flag at its named bit so callers never hand-order the vector.
  function automatic logic [FLAG_W-1:0] make_flags(input logic tmo, input logic err,
                                                    input logic inf, input logic nan,
                                                    input logic zero);
    logic [FLAG_W-1:0] f;
    f           = '0;
    f[FLG_TMO]  = tmo;
    f[FLG_ERR]  = err;
    f[FLG_INF]  = inf;
    f[FLG_NAN]  = nan;
    f[FLG_ZERO] = zero;
    return f;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Command, FPU-side and response signals of the issue controller in one bundle.
interface fpu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  import fpu_pkg::*;

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [31:0]       cmd_a_i;
  logic [31:0]       cmd_b_i;
  logic [1:0]        cmd_mode_i;
  logic [TAG_W-1:0]  cmd_tag_i;

  logic              fpu_start_o;
  logic [31:0]       fpu_a_o;
  logic [31:0]       fpu_b_o;
  logic [1:0]        fpu_mode_o;
  logic              fpu_ready_i;
  logic              fpu_done_i;
  logic [31:0]       fpu_s_i;
  logic              fpu_zero_i;
  logic              fpu_nan_i;
  logic              fpu_inf_i;
  logic              fpu_error_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_s_o;
  logic [TAG_W-1:0]  rsp_tag_o;
  logic [FLAG_W-1:0] rsp_flags_o;

  // The controller itself.
  modport slave (
    input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_mode_i, cmd_tag_i,
           fpu_ready_i, fpu_done_i, fpu_s_i, fpu_zero_i, fpu_nan_i, fpu_inf_i, fpu_error_i,
           rsp_ready_i,
    output cmd_ready_o, fpu_start_o, fpu_a_o, fpu_b_o, fpu_mode_o,
           rsp_valid_o, rsp_s_o, rsp_tag_o, rsp_flags_o
  );

  // Its environment: command source, FPU core and response sink.
  modport master (
    output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_mode_i, cmd_tag_i,
           fpu_ready_i, fpu_done_i, fpu_s_i, fpu_zero_i, fpu_nan_i, fpu_inf_i, fpu_error_i,
           rsp_ready_i,
    input  cmd_ready_o, fpu_start_o, fpu_a_o, fpu_b_o, fpu_mode_o,
           rsp_valid_o, rsp_s_o, rsp_tag_o, rsp_flags_o
  );

endinterface

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO: DEPTH entries of packed {tag, mode, b, a}, first-word fall-through head.
module fpu_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 70,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;   // a full FIFO refuses even when popping
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem[rd_ptr_q];
  assign count_o    = count_q;

  // NOTE: the storage array has no reset; occupancy is governed by the pointers
  // and count, so stale entries are never observable and the RAM stays a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data_i;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues buffered FPU commands one at a time, waits for Done (or a watchdog
// timeout) and hands the result back with its tag on a valid/ready port.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter int  TAG_W   = 4,
  parameter int  TIMEOUT = 64,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  fpu_issue_ctrl_if.slave  bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int              ENTRY_W = 66 + TAG_W;
  localparam int              WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WD_W-1:0]    wd_q, wd_next;
  logic               wd_expire;
  logic [31:0]        op_a_q, op_b_q;
  logic [1:0]         op_mode_q;
  logic [TAG_W-1:0]   op_tag_q;
  logic [31:0]        rsp_s_q;
  logic [FLAG_W-1:0]  rsp_flags_q;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;

  fpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (bus.cmd_valid_i),
    .push_data_i ({bus.cmd_tag_i, bus.cmd_mode_i, bus.cmd_b_i, bus.cmd_a_i}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count_o)
  );

  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && bus.fpu_ready_i;
  // The counter is compared after this cycle's increment, so the response
  // lands exactly TIMEOUT cycles after the ISSUE cycle.
  assign wd_next   = wd_q + 1'b1;
  assign wd_expire = (wd_next == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every variable assigned here gets its default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (fifo_pop) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (bus.fpu_done_i || wd_expire) state_d = RESP;
      RESP:  if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are only reloaded on a pop, so they stay frozen from ISSUE through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_mode_q   <= '0;
      op_tag_q    <= '0;
      rsp_s_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            op_a_q    <= fifo_head[31:0];
            op_b_q    <= fifo_head[63:32];
            op_mode_q <= fifo_head[65:64];
            op_tag_q  <= fifo_head[ENTRY_W-1:66];
          end
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          wd_q <= wd_next;
          if (bus.fpu_done_i) begin
            rsp_s_q     <= bus.fpu_s_i;
            rsp_flags_q <= make_flags(1'b0, bus.fpu_error_i, bus.fpu_inf_i,
                                      bus.fpu_nan_i, bus.fpu_zero_i);
          end else if (wd_expire) begin
            rsp_s_q     <= FP32_QNAN;
            rsp_flags_q <= make_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready_o = !fifo_full;
  assign bus.fpu_start_o = (state_q == ISSUE);
  assign bus.fpu_a_o     = op_a_q;
  assign bus.fpu_b_o     = op_b_q;
  assign bus.fpu_mode_o  = op_mode_q;
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_s_o     = rsp_s_q;
  assign bus.rsp_tag_o   = op_tag_q;
  assign bus.rsp_flags_o = rsp_flags_q;
  assign busy_o          = (state_q != IDLE) || !fifo_empty;

endmodule
